// File: rtl/alt_ddrx_bank_cmd_issuer_if.sv
// Request, timer-status, command-offer and timer-strobe signals of one bank's command issuer.
// The slave modport is the issuer's view; the master modport is its environment.
interface alt_ddrx_bank_cmd_issuer_if #(
    parameter int unsigned MEM_IF_ROW_WIDTH = 16
);
    logic                        req_valid;
    logic                        req_ready;
    logic                        req_read;
    logic [MEM_IF_ROW_WIDTH-1:0] req_row;

    logic                        current_state;
    logic [MEM_IF_ROW_WIDTH-1:0] current_row;
    logic                        rdwr_ready;
    logic                        act_ready;
    logic                        pch_ready;

    logic                        cmd_valid;
    logic [1:0]                  cmd_type;
    logic [MEM_IF_ROW_WIDTH-1:0] cmd_row;
    logic                        cmd_auto_pch;
    logic                        cmd_grant;

    logic                        open;
    logic                        close;
    logic                        read;
    logic                        write;
    logic [MEM_IF_ROW_WIDTH-1:0] row_addr;

    modport master (
        output req_valid, req_read, req_row,
        output current_state, current_row, rdwr_ready, act_ready, pch_ready, cmd_grant,
        input  req_ready, cmd_valid, cmd_type, cmd_row, cmd_auto_pch,
        input  open, close, read, write, row_addr
    );

    modport slave (
        input  req_valid, req_read, req_row,
        input  current_state, current_row, rdwr_ready, act_ready, pch_ready, cmd_grant,
        output req_ready, cmd_valid, cmd_type, cmd_row, cmd_auto_pch,
        output open, close, read, write, row_addr
    );
endinterface

// File: rtl/alt_ddrx_bank_cmd_issuer.sv
// Per-bank command sequencer: steps one request through PCH/ACT/RD/WR, offering each command
// when the bank timer allows it and emitting timer strobes in the arbiter's grant cycle.
module alt_ddrx_bank_cmd_issuer #(
    parameter int unsigned MEM_IF_ROW_WIDTH   = 16,
    parameter int unsigned CLOSE_PAGE_POLICY  = 1,
    parameter int unsigned WAIT_COUNTER_WIDTH = 8
) (
    input  logic                             ctl_clk,
    input  logic                             ctl_reset,
    alt_ddrx_bank_cmd_issuer_if.slave        bus,
    output logic                             busy,
    output logic                             starved
);
    localparam logic                          ClosePage = (CLOSE_PAGE_POLICY != 0);
    localparam logic [WAIT_COUNTER_WIDTH-1:0] WaitMax   = '1;

    typedef enum logic [2:0] {StIdle, StEval, StPch, StAct, StRdwr} state_e;

    state_e                        state_q, state_d;
    logic [MEM_IF_ROW_WIDTH-1:0]   row_q;
    logic                          read_q;
    logic [WAIT_COUNTER_WIDTH-1:0] wait_q, wait_d;
    logic                          starved_q;

    logic       accept;
    logic       req_ready;
    logic       cmd_valid;
    logic [1:0] cmd_type;
    logic       cmd_auto_pch;
    logic       granted;
    logic       open_s, close_s, read_s, write_s;

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        accept       = 1'b0;
        req_ready    = 1'b0;
        cmd_valid    = 1'b0;
        cmd_type     = 2'b00;
        cmd_auto_pch = 1'b0;
        open_s       = 1'b0;
        close_s      = 1'b0;
        read_s       = 1'b0;
        write_s      = 1'b0;

        unique case (state_q)
            StIdle: req_ready = 1'b1;
            StPch: begin
                cmd_valid = bus.pch_ready;
                cmd_type  = 2'b00;
            end
            StAct: begin
                cmd_valid = bus.act_ready;
                cmd_type  = 2'b01;
            end
            StRdwr: begin
                cmd_valid    = bus.rdwr_ready;
                cmd_type     = read_q ? 2'b10 : 2'b11;
                cmd_auto_pch = ClosePage;
            end
            default: ;
        endcase

        granted = cmd_valid && bus.cmd_grant;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    wait_d  = '0;
                    state_d = StEval;
                end
            end
            StEval: begin
                if (!bus.current_state) begin
                    state_d = StAct;
                end else if (ClosePage || (bus.current_row != row_q)) begin
                    state_d = StPch;
                end else begin
                    state_d = StRdwr;
                end
            end
            StPch: begin
                if (granted) begin
                    close_s = 1'b1;
                    state_d = StAct;
                end
            end
            StAct: begin
                if (granted) begin
                    open_s  = 1'b1;
                    state_d = StRdwr;
                end
            end
            StRdwr: begin
                if (granted) begin
                    read_s  = read_q;
                    write_s = !read_q;
                    close_s = cmd_auto_pch;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Waiting for a timer flag or the arbiter both count as starvation time.
        if ((state_q == StPch || state_q == StAct || state_q == StRdwr) && !granted &&
            (wait_q != WaitMax)) begin
            wait_d = wait_q + 1'b1;
        end

        // Reset abandons any request in flight without emitting a strobe.
        if (ctl_reset) begin
            req_ready = 1'b0;
            cmd_valid = 1'b0;
            open_s    = 1'b0;
            close_s   = 1'b0;
            read_s    = 1'b0;
            write_s   = 1'b0;
        end
    end

    always_ff @(posedge ctl_clk) begin
        if (ctl_reset) begin
            state_q   <= StIdle;
            row_q     <= '0;
            read_q    <= 1'b0;
            wait_q    <= '0;
            starved_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            starved_q <= (wait_d == WaitMax);
            if (accept) begin
                row_q  <= bus.req_row;
                read_q <= bus.req_read;
            end
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.cmd_valid    = cmd_valid;
    assign bus.cmd_type     = cmd_type;
    assign bus.cmd_row      = row_q;
    assign bus.cmd_auto_pch = cmd_auto_pch;
    assign bus.open         = open_s;
    assign bus.close        = close_s;
    assign bus.read         = read_s;
    assign bus.write        = write_s;
    assign bus.row_addr     = row_q;
    assign busy             = (state_q != StIdle);
    assign starved          = starved_q;
endmodule

// File: tb/tb_alt_ddrx_bank_cmd_issuer.sv
// Bench for alt_ddrx_bank_cmd_issuer: a close-page and an open-page instance share stimulus;
// expected strobe events are queued by the stimulus and matched by a monitor on the selected DUT.
module tb_alt_ddrx_bank_cmd_issuer;
    localparam int unsigned RW = 16;

    typedef struct packed {
        logic          o;
        logic          c;
        logic          r;
        logic          w;
        logic [RW-1:0] row;
        logic          ap;
    } evt_t;

    logic ctl_clk = 1'b0;
    logic ctl_reset = 1'b1;
    always #5 ctl_clk = ~ctl_clk;

    logic          req_valid, req_read, current_state, rdwr_ready, act_ready, pch_ready, cmd_grant;
    logic [RW-1:0] req_row, current_row;
    logic          sel_cp;
    logic          cp_busy, cp_starved, op_busy, op_starved;

    alt_ddrx_bank_cmd_issuer_if #(.MEM_IF_ROW_WIDTH(RW)) cp_if ();
    alt_ddrx_bank_cmd_issuer_if #(.MEM_IF_ROW_WIDTH(RW)) op_if ();

    assign cp_if.req_valid     = req_valid;
    assign cp_if.req_read      = req_read;
    assign cp_if.req_row       = req_row;
    assign cp_if.current_state = current_state;
    assign cp_if.current_row   = current_row;
    assign cp_if.rdwr_ready    = rdwr_ready;
    assign cp_if.act_ready     = act_ready;
    assign cp_if.pch_ready     = pch_ready;
    assign cp_if.cmd_grant     = cmd_grant;
    assign op_if.req_valid     = req_valid;
    assign op_if.req_read      = req_read;
    assign op_if.req_row       = req_row;
    assign op_if.current_state = current_state;
    assign op_if.current_row   = current_row;
    assign op_if.rdwr_ready    = rdwr_ready;
    assign op_if.act_ready     = act_ready;
    assign op_if.pch_ready     = pch_ready;
    assign op_if.cmd_grant     = cmd_grant;

    alt_ddrx_bank_cmd_issuer #(
        .MEM_IF_ROW_WIDTH(RW), .CLOSE_PAGE_POLICY(1), .WAIT_COUNTER_WIDTH(8)
    ) u_cp (
        .ctl_clk(ctl_clk), .ctl_reset(ctl_reset), .bus(cp_if.slave),
        .busy(cp_busy), .starved(cp_starved)
    );

    alt_ddrx_bank_cmd_issuer #(
        .MEM_IF_ROW_WIDTH(RW), .CLOSE_PAGE_POLICY(0), .WAIT_COUNTER_WIDTH(8)
    ) u_op (
        .ctl_clk(ctl_clk), .ctl_reset(ctl_reset), .bus(op_if.slave),
        .busy(op_busy), .starved(op_starved)
    );

    logic          o_req_ready, o_cmd_valid, o_auto, o_open, o_close, o_read, o_write;
    logic          o_busy, o_starved;
    logic [1:0]    o_cmd_type;
    logic [RW-1:0] o_row_addr, o_cmd_row;

    assign o_req_ready = sel_cp ? cp_if.req_ready    : op_if.req_ready;
    assign o_cmd_valid = sel_cp ? cp_if.cmd_valid    : op_if.cmd_valid;
    assign o_cmd_type  = sel_cp ? cp_if.cmd_type     : op_if.cmd_type;
    assign o_cmd_row   = sel_cp ? cp_if.cmd_row      : op_if.cmd_row;
    assign o_auto      = sel_cp ? cp_if.cmd_auto_pch : op_if.cmd_auto_pch;
    assign o_open      = sel_cp ? cp_if.open         : op_if.open;
    assign o_close     = sel_cp ? cp_if.close        : op_if.close;
    assign o_read      = sel_cp ? cp_if.read         : op_if.read;
    assign o_write     = sel_cp ? cp_if.write        : op_if.write;
    assign o_row_addr  = sel_cp ? cp_if.row_addr     : op_if.row_addr;
    assign o_busy      = sel_cp ? cp_busy            : op_busy;
    assign o_starved   = sel_cp ? cp_starved         : op_starved;

    int   errors = 0;
    int   checks = 0;
    evt_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_evt(input logic o, input logic c, input logic r, input logic w,
                            input logic [RW-1:0] row, input logic ap);
        evt_t e;
        e = {o, c, r, w, row, ap};
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge ctl_clk);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    task automatic do_reset();
        ctl_reset = 1'b1;
        step();
        ctl_reset = 1'b0;
    endtask

    // Leaves the caller at the start of the EVAL cycle.
    task automatic issue(input logic [RW-1:0] row, input logic rd);
        int n;
        n         = 0;
        req_row   = row;
        req_read  = rd;
        req_valid = 1'b1;
        mid();
        while (!o_req_ready && n < 50) begin
            step();
            mid();
            n++;
        end
        check("accept_ready", 32'(o_req_ready), 1);
        step();
        req_valid = 1'b0;
    endtask

    // Every strobe cycle must match the next queued expectation.
    always @(negedge ctl_clk) begin
        evt_t got, e;
        if (o_open || o_close || o_read || o_write) begin
            got = {o_open, o_close, o_read, o_write, o_row_addr, o_auto};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: got %h, required no strobe", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL strobe_evt: got %h, required %h", got, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        sel_cp = 1'b1;
        req_valid = 1'b1; req_read = 1'b0; req_row = '0;
        current_state = 1'b0; current_row = '0;
        rdwr_ready = 1'b0; act_ready = 1'b0; pch_ready = 1'b0; cmd_grant = 1'b0;

        // Reset forces handshake outputs low even with a request pending.
        repeat (3) step();
        mid();
        check("rst_req_ready", 32'(o_req_ready), 0);
        check("rst_cmd_valid", 32'(o_cmd_valid), 0);
        step();
        ctl_reset = 1'b0;
        req_valid = 1'b0;
        mid();
        check("rst_busy", 32'(o_busy), 0);
        check("rst_starved", 32'(o_starved), 0);
        check("rst_req_ready_after", 32'(o_req_ready), 1);

        // Close-page, idle bank: ACT then RD with auto-precharge.
        do_reset();
        sel_cp = 1'b1;
        current_state = 1'b0;
        rdwr_ready = 1'b1; act_ready = 1'b1; pch_ready = 1'b1; cmd_grant = 1'b1;
        push_evt(1, 0, 0, 0, 16'h0012, 0);
        push_evt(0, 1, 1, 0, 16'h0012, 1);
        issue(16'h0012, 1'b1);
        mid();
        check("t1_eval_busy", 32'(o_busy), 1);
        check("t1_eval_cmd_valid", 32'(o_cmd_valid), 0);
        step(); mid();
        check("t1_act_type", 32'(o_cmd_type), 1);
        check("t1_open", 32'(o_open), 1);
        check("t1_cmd_row", 32'(o_cmd_row), 32'h12);
        step(); mid();
        check("t1_rd_type", 32'(o_cmd_type), 2);
        check("t1_read_close", 32'({o_read, o_close}), 3);
        step(); mid();
        check("t1_idle_ready", 32'(o_req_ready), 1);

        // Open-page row hit: straight to WR, no auto-precharge.
        do_reset();
        sel_cp = 1'b0;
        current_state = 1'b1; current_row = 16'h0055;
        push_evt(0, 0, 0, 1, 16'h0055, 0);
        issue(16'h0055, 1'b0);
        step(); mid();
        check("t2_type", 32'(o_cmd_type), 3);
        check("t2_auto", 32'(o_auto), 0);
        check("t2_write", 32'(o_write), 1);
        step(); mid();
        check("t2_idle_ready", 32'(o_req_ready), 1);

        // Open-page row miss with precharge held off for five cycles.
        do_reset();
        sel_cp = 1'b0;
        pch_ready = 1'b0;
        push_evt(0, 1, 0, 0, 16'h0066, 0);
        push_evt(1, 0, 0, 0, 16'h0066, 0);
        push_evt(0, 0, 1, 0, 16'h0066, 0);
        issue(16'h0066, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(); mid();
            check("t3_pch_wait_valid", 32'(o_cmd_valid), 0);
        end
        step();
        pch_ready = 1'b1;
        mid();
        check("t3_close", 32'(o_close), 1);
        step(); mid();
        check("t3_open", 32'(o_open), 1);
        step(); mid();
        check("t3_read", 32'(o_read), 1);
        step(); mid();
        check("t3_idle_ready", 32'(o_req_ready), 1);

        // Starvation: ACT offered but never granted for 300 cycles.
        do_reset();
        sel_cp = 1'b1;
        current_state = 1'b0; cmd_grant = 1'b0;
        push_evt(1, 0, 0, 0, 16'h003A, 0);
        push_evt(0, 1, 1, 0, 16'h003A, 1);
        issue(16'h003A, 1'b1);
        for (int i = 1; i <= 300; i++) begin
            step(); mid();
            if (i == 1) check("t4_act_valid", 32'(o_cmd_valid), 1);
            if (i == 255) check("t4_starved_before", 32'(o_starved), 0);
            if (i == 256) check("t4_starved_set", 32'(o_starved), 1);
            if (i == 300) check("t4_starved_held", 32'(o_starved), 1);
        end
        step();
        cmd_grant = 1'b1;
        mid();
        check("t4_open", 32'(o_open), 1);
        step(); mid();
        check("t4_read", 32'(o_read), 1);
        step(); mid();
        check("t4_starved_idle", 32'(o_starved), 1);
        push_evt(1, 0, 0, 0, 16'h003B, 0);
        push_evt(0, 1, 1, 0, 16'h003B, 1);
        issue(16'h003B, 1'b1);
        mid();
        check("t4_starved_clear", 32'(o_starved), 0);
        step(); step(); step(); mid();
        check("t4_idle_ready", 32'(o_req_ready), 1);

        // Grant without rdwr_ready is ignored.
        do_reset();
        sel_cp = 1'b0;
        current_state = 1'b1; current_row = 16'h0055;
        rdwr_ready = 1'b0; cmd_grant = 1'b1;
        push_evt(0, 0, 1, 0, 16'h0055, 0);
        issue(16'h0055, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(); mid();
            check("t5_hold_valid", 32'(o_cmd_valid), 0);
            check("t5_hold_busy", 32'(o_busy), 1);
        end
        step();
        rdwr_ready = 1'b1;
        mid();
        check("t5_read", 32'(o_read), 1);
        step(); mid();
        check("t5_idle_ready", 32'(o_req_ready), 1);

        // Reset in RDWR with grant suppresses the strobe.
        do_reset();
        sel_cp = 1'b0;
        issue(16'h0055, 1'b1);
        step();
        ctl_reset = 1'b1;
        mid();
        check("t6_no_read", 32'(o_read), 0);
        check("t6_no_valid", 32'(o_cmd_valid), 0);
        step();
        ctl_reset = 1'b0;
        mid();
        check("t6_busy", 32'(o_busy), 0);
        check("t6_req_ready", 32'(o_req_ready), 1);

        step();
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alt_ddrx_bank_cmd_issuer.md
Name: alt_ddrx_bank_cmd_issuer

Overview:
- Per-bank command sequencer. It drives the open/close/read/write event strobes into that bank's timer-info block and consumes the timer's state, row and ready flags.
- It accepts one access request at a time (row, read/write) and steps it through the required sequence (PCH, ACT, RD/WR) for one bank.
- Each step raises cmd_valid only when the matching timer ready flag allows it. The step completes when the shared command-bus arbiter returns cmd_grant.

Parameters:
- MEM_IF_ROW_WIDTH, 16, width of row address.
- CLOSE_PAGE_POLICY, 1. When 1, every RD/WR carries auto-precharge and open rows are never reused. When 0, the block uses open-page policy with row-hit detection.
- WAIT_COUNTER_WIDTH, 8, width of the saturating per-request wait counter.

Ports:
- ctl_clk  in  1  controller clock; all logic on the rising edge.
- ctl_reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_read  in  1  1 = read, 0 = write.
- req_row  in  MEM_IF_ROW_WIDTH  target row.
- current_state  in  1  bank status from timer: 0 = IDLE, 1 = ACTIVE.
- current_row  in  MEM_IF_ROW_WIDTH  open row from timer; used only when CLOSE_PAGE_POLICY = 0.
- rdwr_ready  in  1  tRCD satisfied.
- act_ready  in  1  tRC and precharge-to-act satisfied.
- pch_ready  in  1  tRAS and rd/wr-to-pch satisfied.
- cmd_valid  out  1  command offered to arbiter.
- cmd_type  out  2  00 = PCH, 01 = ACT, 10 = RD, 11 = WR.
- cmd_row  out  MEM_IF_ROW_WIDTH  latched request row.
- cmd_auto_pch  out  1  RD/WR with auto-precharge.
- cmd_grant  in  1  arbiter accepted the offered command.
- open  out  1  ACT issued (strobe to timer).
- close  out  1  PCH or auto-precharge issued.
- read  out  1  RD issued.
- write  out  1  WR issued.
- row_addr  out  MEM_IF_ROW_WIDTH  row for the open strobe; equals cmd_row.
- busy  out  1  request in flight (state != IDLE).
- starved  out  1  wait counter saturated.

Behaviour:
- Reset (ctl_reset = 1 at a clock edge):
  - State goes to IDLE; latched row/read, wait counter and starved clear.
  - While ctl_reset is high, req_ready, cmd_valid and all strobes are forced to 0. Asserting reset mid-request abandons the request; no strobe is emitted.
- States: IDLE, EVAL, PCH, ACT, RDWR.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: latch req_row and req_read, clear the wait counter, go to EVAL.
- EVAL (always one cycle; inputs only sampled, no command):
  - !current_state -> ACT.
  - current_state, CLOSE_PAGE_POLICY = 1 -> PCH.
  - current_state, CLOSE_PAGE_POLICY = 0, current_row == latched row -> RDWR (row hit).
  - current_state, CLOSE_PAGE_POLICY = 0, mismatch -> PCH.
- PCH:
  - cmd_valid = pch_ready, cmd_type = 00.
  - On cmd_valid && cmd_grant: close = 1 for one cycle, then go to ACT.
- ACT:
  - cmd_valid = act_ready, cmd_type = 01.
  - On grant: open = 1, row_addr = latched row, then go to RDWR.
- RDWR:
  - cmd_valid = rdwr_ready; cmd_type = 10 if latched read, else 11; cmd_auto_pch = CLOSE_PAGE_POLICY.
  - On grant: read or write = 1. close = 1 in the same cycle when cmd_auto_pch. Then go to IDLE.
- cmd_valid, cmd_type and the strobes are combinational from state, the ready inputs and cmd_grant. They are never registered, so a strobe occurs in exactly the cycle of the grant.
- cmd_grant while cmd_valid = 0 is ignored; the state is held.
- A ready flag that drops with no grant in that cycle withdraws cmd_valid; no strobe is emitted and the state is held.
- At most one of open, read, write is high per cycle. close may coincide only with read or write.
- cmd_type/cmd_row are don't-care when cmd_valid = 0, but cmd_row always reflects the latched row.
- Wait counter:
  - Increments each cycle in PCH/ACT/RDWR without a grant.
  - Saturates at all-ones; no wrap.
  - Clears on request accept.
  - starved = (counter == all-ones), registered.
- No back-to-back accept: after a RDWR grant, the block passes through IDLE for one cycle before the next request can enter EVAL.
- Throughput minimum: 1 request per 3 cycles (row hit, open-page); 4 cycles for ACT+RDWR; 5 for PCH+ACT+RDWR, all with readies and grants held high.

Test Plan:
- Close-page, bank idle, all readies and grant = 1, read to row 0x12: accept at cycle 0, EVAL at 1, open with row_addr 0x0012 at 2, read + close at 3, req_ready high again at 4.
- Open-page, current_state = 1, current_row = 0x55, write to row 0x55: EVAL -> RDWR; write strobe with cmd_auto_pch = 0; no open or close strobe.
- Open-page, current_state = 1, current_row = 0x55, read to 0x66, pch_ready low for 5 cycles: cmd_valid low 5 cycles; then close, open (row 0x66), read in successive grant cycles.
- act_ready = 1, cmd_grant held 0 for 300 cycles, WAIT_COUNTER_WIDTH = 8: starved goes high after 255 wait cycles and stays high; a grant completes ACT; starved clears on the next accept.
- Grant asserted while rdwr_ready = 0: no read/write strobe, state held; the strobe occurs in the first cycle with both rdwr_ready and grant high.
- ctl_reset pulsed in RDWR with rdwr_ready and grant high: no read strobe that cycle; next cycle state IDLE, busy = 0, req_ready = 1.
